rc_resistance_calc: RTL and testbench

RC_RESISTANCE_CALC -- requirements
Module: rc_resistance_calc

---
 rtl/rc_tdc_pkg.sv | 15 +
 rtl/rc_seq_divider.sv | 65 ++++++
 rtl/rc_resistance_calc.sv | 137 +++++++++++++
 tb/tb_rc_resistance_calc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_tdc_pkg.sv
// Shared constants and FSM state type for the RC resistance measurement path.
package rc_tdc_pkg;

  localparam int RC_CAP_PF   = 100;
  localparam int RC_LN2_X100 = 69;
  localparam int RC_DIVISOR  = RC_CAP_PF * RC_LN2_X100;
  localparam int RC_CNT_W    = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } rc_state_e;

endpackage

// File: rtl/rc_seq_divider.sv
// Restoring shift-subtract divider by a constant, one quotient bit per cycle.
// The first bit is resolved on the start edge itself, so the quotient is
// complete CNT_W edges after start and done pulses in that cycle.
module rc_seq_divider #(
  parameter int DIVISOR = 6900,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  output logic [CNT_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(CNT_W + 1);
  localparam logic [CNT_W:0] DIV_V = (CNT_W + 1)'(DIVISOR);

  logic [CNT_W-1:0] rem_q, quo_q, src_rem, src_quo, rem_nxt, quo_nxt;
  logic [CNT_W:0]   shifted, diff;
  logic             fits;
  logic [CW-1:0]    cnt_q;
  logic             running_q;

  // One restoring step, taken from the fresh operand on start or the running state otherwise.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    shifted = {src_rem, src_quo[CNT_W-1]};
    diff    = shifted - DIV_V;
    fits    = (shifted >= DIV_V);
    rem_nxt = fits ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    quo_nxt = {src_quo[CNT_W-2:0], fits};
  end

  // Iteration registers with a down-counter marking the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q     <= rem_nxt;
        quo_q     <= quo_nxt;
        cnt_q     <= CW'(CNT_W - 1);
        running_q <= 1'b1;
      end else if (running_q) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          running_q <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/rc_resistance_calc.sv
// Converts a raw RC charge-time count into an 8-bit saturated resistance code.
// Optional macro RC_AVG_EN: output a 4-sample moving average instead of the
// single result (one extra cycle of latency, first output after 4 samples).
module rc_resistance_calc
  import rc_tdc_pkg::*;
#(
  parameter int DIVISOR = RC_DIVISOR,
  parameter int CNT_W   = RC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_valid,
  input  logic             overflow_in,
  output logic             busy,
  output logic [7:0]       res_out,
  output logic             res_valid,
  output logic             res_sat
);

  rc_state_e        state_q, state_d;
  logic             div_start, div_done;
  logic [CNT_W-1:0] quo;
  logic             load_evt;
  logic [7:0]       new_res;
  logic             new_sat;

  rc_seq_divider #(.DIVISOR(DIVISOR), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (count_in),
    .quotient (quo),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, divider start and result-load strobe; a result is loaded on the
  // edge entering DONE, so it is visible together with res_valid in DONE.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    load_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_valid) begin
          if (overflow_in) begin
            state_d  = DONE;
            load_evt = 1'b1;
          end else begin
            state_d   = DIVIDE;
            div_start = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          state_d  = DONE;
          load_evt = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturated single-sample result; a load from IDLE is always the overflow path.
  always_comb begin
    new_sat = (state_q == IDLE) || (|quo[CNT_W-1:8]);
    new_res = new_sat ? 8'hFF : quo[7:0];
  end

  assign busy = (state_q != IDLE);

`ifdef RC_AVG_EN
  logic [3:0][7:0] hist_res_q;
  logic [3:0]      hist_sat_q;
  logic [2:0]      fill_q;
  logic            avg_pend_q;
  logic [9:0]      sum;

  assign sum = 10'(hist_res_q[0]) + 10'(hist_res_q[1]) + 10'(hist_res_q[2]) + 10'(hist_res_q[3]);

  // Sample history and fill count; averaging runs the cycle after a sample lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_res_q <= '0;
      hist_sat_q <= '0;
      fill_q     <= '0;
      avg_pend_q <= 1'b0;
    end else begin
      avg_pend_q <= load_evt;
      if (load_evt) begin
        hist_res_q <= {hist_res_q[2:0], new_res};
        hist_sat_q <= {hist_sat_q[2:0], new_sat};
        if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
      end
    end
  end

  // Averaged output, withheld until the window holds four samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_out   <= '0;
      res_sat   <= 1'b0;
    end else begin
      res_valid <= avg_pend_q && (fill_q == 3'd4);
      if (avg_pend_q && (fill_q == 3'd4)) begin
        res_out <= sum[9:2];
        res_sat <= |hist_sat_q;
      end
    end
  end
`else
  // Output registers hold the last result between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_out   <= '0;
      res_sat   <= 1'b0;
    end else begin
      res_valid <= load_evt;
      if (load_evt) begin
        res_out <= new_res;
        res_sat <= new_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rc_resistance_calc.sv
// Self-checking bench for rc_resistance_calc against an arithmetic reference model.
module tb_rc_resistance_calc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] count_in = '0;
  logic        count_valid = 1'b0;
  logic        overflow_in = 1'b0;
  logic        busy, res_valid, res_sat;
  logic [7:0]  res_out;

  int errors = 0;
  int checks = 0;

  int         hist_r[$];
  bit         hist_s[$];
  int         nsamp;
  logic [7:0] last_r;
  logic       last_s;

  rc_resistance_calc dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .overflow_in (overflow_in),
    .busy        (busy),
    .res_out     (res_out),
    .res_valid   (res_valid),
    .res_sat     (res_sat)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist_r.delete();
    hist_s.delete();
    nsamp  = 0;
    last_r = '0;
    last_s = 1'b0;
  endtask

  // Reference: floor(count/6900), clipped to 255; optional 4-sample average.
  task automatic model_push(input logic [23:0] cnt, input bit ovf,
                            output bit v, output logic [7:0] r, output logic s, output int lat);
    int q, qr, sum;
    bit qs, so;
    q  = int'(cnt) / 6900;
    qs = ovf || (q > 255);
    qr = qs ? 255 : q;
    lat = ovf ? 1 : 25;
`ifdef RC_AVG_EN
    hist_r.push_back(qr);
    hist_s.push_back(qs);
    if (hist_r.size() > 4) begin
      void'(hist_r.pop_front());
      void'(hist_s.pop_front());
    end
    nsamp++;
    sum = 0;
    so  = 0;
    foreach (hist_r[i]) sum += hist_r[i];
    foreach (hist_s[i]) so |= hist_s[i];
    v   = (nsamp >= 4);
    r   = 8'(sum / 4);
    s   = so;
    lat = lat + 1;
`else
    sum = 0;
    so  = 0;
    v   = 1;
    r   = 8'(qr);
    s   = qs;
`endif
    if (v) begin
      last_r = r;
      last_s = s;
    end
  endtask

  // Pulse one request in cycle 0, optionally a second one in cycle intr, and watch 60 cycles.
  task automatic drive_watch(input logic [23:0] cnt, input bit ovf, input int intr,
                             input logic [23:0] intr_cnt, output int nvalid, output int lat,
                             output logic [7:0] r, output logic s, output logic busy1);
    @(posedge clk);
    #1;
    count_in    = cnt;
    overflow_in = ovf;
    count_valid = 1'b1;
    nvalid = 0;
    lat    = -1;
    r      = '0;
    s      = 1'b0;
    busy1  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      count_valid = (k == intr);
      count_in    = intr_cnt;
      overflow_in = 1'b0;
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (res_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = k;
          r   = res_out;
          s   = res_sat;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    checks++; if (res_out !== 8'd0)   begin errors++; $display("FAIL reset_out: got %0d want 0", res_out); end
    checks++; if (res_sat !== 1'b0)   begin errors++; $display("FAIL reset_sat: got %b want 0", res_sat); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [23:0] cnts[8] = '{24'd690000, 24'd1766400, 24'd1759500, 24'd6899,
                             24'd6900, 24'd0, 24'd123456, 24'd0};
    bit          ovfs[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    bit v; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    for (int i = 0; i < 8; i++) begin
      model_push(cnts[i], ovfs[i], v, er, es, elat);
      drive_watch(cnts[i], ovfs[i], 0, 24'd0, nv, lat, r, s, b1);
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL dir%0d_busy: got %b want 1", i, b1); end
      checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL dir%0d_nvalid: got %0d want %0d", i, nv, v ? 1 : 0); end
      if (v) begin
        checks++; if (lat != elat) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); end
        checks++; if (r !== er) begin errors++; $display("FAIL dir%0d_res: got %0d want %0d", i, r, er); end
        checks++; if (s !== es) begin errors++; $display("FAIL dir%0d_sat: got %b want %b", i, s, es); end
      end
      checks++; if (res_out !== last_r || res_sat !== last_s)
        begin errors++; $display("FAIL dir%0d_hold: got %0d/%b want %0d/%b", i, res_out, res_sat, last_r, last_s); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_idle: busy got %b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    bit v, ovf; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    logic [23:0] cnt;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) cnt = 24'($urandom_range(0, 1900000));
      else                           cnt = 24'($urandom);
      ovf = ($urandom_range(0, 7) == 0);
      model_push(cnt, ovf, v, er, es, elat);
      drive_watch(cnt, ovf, 0, 24'd0, nv, lat, r, s, b1);
      checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_nvalid cnt=%0d: got %0d want %0d", i, cnt, nv, v ? 1 : 0); end
      if (v) begin
        checks++; if (lat != elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
        checks++; if (r !== er || s !== es)
          begin errors++; $display("FAIL rnd%0d_result cnt=%0d ovf=%b: got %0d/%b want %0d/%b", i, cnt, ovf, r, s, er, es); end
      end
      checks++; if (res_out !== last_r) begin errors++; $display("FAIL rnd%0d_hold: got %0d want %0d", i, res_out, last_r); end
    end
  endtask

  // A second request arrives mid-divide (cycle 10) and must not disturb the first.
  task automatic test_ignore_busy();
    bit v; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    model_push(24'd690000, 1'b0, v, er, es, elat);
    drive_watch(24'd690000, 1'b0, 10, 24'd6900, nv, lat, r, s, b1);
    checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL busy_ignore_nvalid: got %0d want %0d", nv, v ? 1 : 0); end
    if (v) begin
      checks++; if (r !== er || lat != elat)
        begin errors++; $display("FAIL busy_ignore_result: got %0d@%0d want %0d@%0d", r, lat, er, elat); end
    end
  endtask

  // A request coinciding with DONE (cycle 25 divide path, cycle 1 overflow path) is dropped.
  task automatic test_ignore_done();
    bit v; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    model_push(24'd690000, 1'b0, v, er, es, elat);
    drive_watch(24'd690000, 1'b0, 25, 24'd6900, nv, lat, r, s, b1);
    checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL done_ignore_div_nvalid: got %0d want %0d", nv, v ? 1 : 0); end
    checks++; if (res_out !== last_r) begin errors++; $display("FAIL done_ignore_div_hold: got %0d want %0d", res_out, last_r); end
    model_push(24'd42, 1'b1, v, er, es, elat);
    drive_watch(24'd42, 1'b1, 1, 24'd6900, nv, lat, r, s, b1);
    checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL done_ignore_ovf_nvalid: got %0d want %0d", nv, v ? 1 : 0); end
    checks++; if (res_out !== last_r) begin errors++; $display("FAIL done_ignore_ovf_hold: got %0d want %0d", res_out, last_r); end
  endtask

  task automatic test_reset_mid();
    bit v; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    @(posedge clk);
    #1;
    count_in    = 24'd690000;
    overflow_in = 1'b0;
    count_valid = 1'b1;
    @(posedge clk);
    #1;
    count_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || res_out !== 8'd0 || res_sat !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs: got busy=%b valid=%b out=%0d sat=%b want all 0", busy, res_valid, res_out, res_sat); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) nv++;
    end
    checks++; if (nv != 0) begin errors++; $display("FAIL midreset_no_valid: got %0d want 0", nv); end
    model_push(24'd69000, 1'b0, v, er, es, elat);
    drive_watch(24'd69000, 1'b0, 0, 24'd0, nv, lat, r, s, b1);
    checks++; if (nv != (v ? 1 : 0)) begin errors++; $display("FAIL midreset_fresh_nvalid: got %0d want %0d", nv, v ? 1 : 0); end
    if (v) begin
      checks++; if (r !== er || lat != elat)
        begin errors++; $display("FAIL midreset_fresh_result: got %0d@%0d want %0d@%0d", r, lat, er, elat); end
    end
  endtask

`ifdef RC_AVG_EN
  task automatic test_avg();
    logic [23:0] cnts[5] = '{24'd69000, 24'd138000, 24'd207000, 24'd276000, 24'd345000};
    int          wantn[5] = '{0, 0, 0, 1, 1};
    int          wantr[5] = '{0, 0, 0, 25, 35};
    bit v; logic [7:0] er, r; logic es, s, b1; int elat, nv, lat;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      model_push(cnts[i], 1'b0, v, er, es, elat);
      drive_watch(cnts[i], 1'b0, 0, 24'd0, nv, lat, r, s, b1);
      checks++; if (nv != wantn[i]) begin errors++; $display("FAIL avg%0d_nvalid: got %0d want %0d", i, nv, wantn[i]); end
      if (wantn[i] == 1) begin
        checks++; if (r !== 8'(wantr[i]) || lat != 26)
          begin errors++; $display("FAIL avg%0d_result: got %0d@%0d want %0d@26", i, r, lat, wantr[i]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_ignore_done();
    test_reset_mid();
`ifdef RC_AVG_EN
    test_avg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
